// File: rtl/conv_pkg.sv
// Shared widths, phase encodings, FSM states and the kernel-row selector
// used by the conv window feeder and its line buffers.
package conv_pkg;

   localparam int PIX_W = 8;
   localparam int KTAPS = 3;
   localparam int ROW_W = KTAPS * PIX_W;
   localparam int KER_W = KTAPS * ROW_W;
   localparam int RES_W = 20;

   typedef logic [1:0] phase_t;
   localparam phase_t PH_0 = 2'd0;
   localparam phase_t PH_1 = 2'd1;
   localparam phase_t PH_2 = 2'd2;
   localparam phase_t PH_3 = 2'd3;

   typedef logic [1:0] fsm_state_t;
   localparam fsm_state_t ST_FILL = 2'd0;
   localparam fsm_state_t ST_RUN  = 2'd1;
   localparam fsm_state_t ST_WRAP = 2'd2;

   // Byte c of the result is tap (r,c), or tap (2-r,2-c) when flip is set.
   function automatic logic [ROW_W-1:0] ker_row(input logic [KER_W-1:0] k,
                                                input logic [1:0]       r,
                                                input logic             flip);
      logic [ROW_W-1:0] row;
      int tr;
      int tc;
      row = '0;
      for (int c = 0; c < KTAPS; c++) begin
         tr = flip ? (KTAPS - 1) - int'(r) : int'(r);
         tc = flip ? (KTAPS - 1) - c : c;
         row[c*PIX_W +: PIX_W] = k[(KTAPS*tr + tc)*PIX_W +: PIX_W];
      end
      return row;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixels: single-port RAM, registered read, read-before-write.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [PIX_W-1:0] wdata_i,
   output logic [PIX_W-1:0] rdata_o
);

   logic [PIX_W-1:0] mem_q [DEPTH];
   logic [PIX_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_window_feeder.sv
// Builds 3x3 windows from a raster stream and feeds the MAC one kernel row
// per cycle. Define FEEDER_KFLIP_EN to rotate the kernel 180 degrees.
//
// state | meaning
// FILL  | current position cannot complete a window (row<2 or col<2)
// RUN   | next accepted pixel completes a window
// WRAP  | row/col just returned to 0; falls back to FILL next cycle
module conv_window_feeder
   import conv_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic             k_load,
   input  logic [KER_W-1:0] k_coef,
   output logic [ROW_W-1:0] data,
   output logic [ROW_W-1:0] weight,
   output logic             res_valid
);

   localparam int AW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

`ifdef FEEDER_KFLIP_EN
   localparam logic KFLIP = 1'b1;
`else
   localparam logic KFLIP = 1'b0;
`endif

   phase_t                      phase_q, phase_d;
   fsm_state_t                  state_q, state_d;
   logic [AW-1:0]               col_q, col_d;
   logic [RW-1:0]               row_q, row_d;
   logic [KTAPS-1:0][ROW_W-1:0] win_q, win_d;
   logic [KER_W-1:0]            kern_q, kern_d;
   logic                        ok_q, ok_d;
   logic [ROW_W-1:0]            data_q, data_d;
   logic [ROW_W-1:0]            weight_q, weight_d;
   logic                        res_valid_q, res_valid_d;
   logic [PIX_W-1:0]            lb0_rd, lb1_rd;
   logic                        accept;

   assign pix_ready = (phase_q == PH_0);
   assign accept    = pix_valid && pix_ready;

   conv_line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb0 (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (col_q),
      .wdata_i (pix_in),
      .rdata_o (lb0_rd)
   );

   conv_line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb1 (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (col_q),
      .wdata_i (lb0_rd),
      .rdata_o (lb1_rd)
   );

   always_comb begin
      phase_d  = phase_q + 2'd1;
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      win_d    = win_q;
      kern_d   = kern_q;
      ok_d     = ok_q;
      data_d   = '0;
      weight_d = '0;

      if (phase_q == PH_0) begin
         ok_d = 1'b0;
         if (k_load) begin
            kern_d = k_coef;
         end
      end
      if (state_q == ST_WRAP) begin
         state_d = ST_FILL;
      end

      if (accept) begin
         win_d[0] = {lb1_rd, win_q[0][ROW_W-1:PIX_W]};
         win_d[1] = {lb0_rd, win_q[1][ROW_W-1:PIX_W]};
         win_d[2] = {pix_in, win_q[2][ROW_W-1:PIX_W]};
         ok_d     = (state_q == ST_RUN);
         if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + AW'(1);
         end
         if (col_q == LAST_COL && row_q == LAST_ROW) begin
            state_d = ST_WRAP;
         end else if (row_d >= RW'(2) && col_d >= AW'(2)) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_FILL;
         end
      end

      // Outputs are registered, so select on the phase they will be seen in.
      case (phase_d)
         PH_1: begin
            data_d   = win_d[0];
            weight_d = ker_row(kern_d, 2'd0, KFLIP);
         end
         PH_2: begin
            data_d   = win_d[1];
            weight_d = ker_row(kern_d, 2'd1, KFLIP);
         end
         PH_3: begin
            data_d   = win_d[2];
            weight_d = ker_row(kern_d, 2'd2, KFLIP);
         end
         default: begin
            data_d   = '0;
            weight_d = '0;
         end
      endcase
      if (!ok_d) begin
         data_d   = '0;
         weight_d = '0;
      end

      res_valid_d = (phase_d == PH_0) && ok_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= PH_0;
         state_q     <= ST_FILL;
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '0;
         kern_q      <= '0;
         ok_q        <= 1'b0;
         data_q      <= '0;
         weight_q    <= '0;
         res_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         kern_q      <= kern_d;
         ok_q        <= ok_d;
         data_q      <= data_d;
         weight_q    <= weight_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign data      = data_q;
   assign weight    = weight_q;
   assign res_valid = res_valid_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder with a small behavioural MAC on its outputs.
module tb_conv_window_feeder;
   import conv_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [PIX_W-1:0] pix_in = '0;
   logic             pix_valid = 1'b0;
   logic             pix_ready;
   logic             k_load = 1'b0;
   logic [KER_W-1:0] k_coef = '0;
   logic [ROW_W-1:0] data;
   logic [ROW_W-1:0] weight;
   logic             res_valid;

   int test_cnt = 0;
   int fail_cnt = 0;
   int n_acc    = 0;
   int first_rv = -1;
   int res_q[$];

   conv_window_feeder #(.IMG_W(8), .IMG_H(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .k_load    (k_load),
      .k_coef    (k_coef),
      .data      (data),
      .weight    (weight),
      .res_valid (res_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      test_cnt++;
      if (act != exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int dot(input logic [ROW_W-1:0] d, input logic [ROW_W-1:0] w);
      int s = 0;
      for (int c = 0; c < KTAPS; c++) begin
         s += int'($signed(d[c*PIX_W +: PIX_W])) * int'($signed(w[c*PIX_W +: PIX_W]));
      end
      return s;
   endfunction

   function automatic logic [KER_W-1:0] kfill(input logic [7:0] v);
      logic [KER_W-1:0] k;
      for (int i = 0; i < 9; i++) k[i*8 +: 8] = v;
      return k;
   endfunction

   function automatic logic [KER_W-1:0] ktap(input int idx);
      logic [KER_W-1:0] k = '0;
      k[idx*8 +: 8] = 8'd1;
      return k;
   endfunction

   // Behavioural MAC: sums phases 1-3, result visible in the following phase 0.
   logic [1:0] ph = 2'd0;
   int         acc = 0;
   logic signed [RES_W-1:0] res_trunc;
   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         ph  = 2'd0;
         acc = 0;
      end else begin
         ph = ph + 2'd1;
         chk("pix_ready_phase", longint'(pix_ready), longint'(ph == 2'd0));
         chk("res_valid_phase", longint'(res_valid && ph != 2'd0), 0);
         if (ph == 2'd0) begin
            chk("data_zero_ph0", longint'(data | weight), 0);
            if (res_valid) begin
               res_trunc = RES_W'(acc);
               res_q.push_back(int'(res_trunc));
               if (first_rv < 0) first_rv = n_acc;
            end
            acc = 0;
         end else begin
            acc += dot(data, weight);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      pix_valid = 1'b0;
      k_load = 1'b0;
      repeat (2) @(negedge clk);
      res_q.delete();
      n_acc = 0;
      first_rv = -1;
      rst = 1'b0;
   endtask

   task automatic feed(input int start, input int n, input int pmode, input logic [7:0] pval,
                       input logic ld, input logic [KER_W-1:0] kern);
      int sent = 0;
      int guard = 0;
      if (ld) k_coef = kern;
      while (sent < n && guard < 8*n + 16) begin
         @(negedge clk);
         guard++;
         pix_valid = 1'b1;
         pix_in = (pmode == 0) ? 8'(start + sent) : pval;
         k_load = ld && (sent == 0);
         if (pix_ready) begin
            sent++;
            n_acc++;
         end
      end
      chk("feed_accepts", sent, n);
      @(negedge clk);
      pix_valid = 1'b0;
      k_load = 1'b0;
   endtask

   typedef struct {
      int               pmode;
      logic [7:0]       pval;
      logic [KER_W-1:0] kern;
      int               a;
      int               b;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int acc_cnt;
      int r0;
      int c0;
      int expv;

      vecs[0] = '{0, 8'h00, kfill(8'h01), 9, 81};
`ifdef FEEDER_KFLIP_EN
      vecs[1] = '{0, 8'h00, ktap(0), 1, 18};
`else
      vecs[1] = '{0, 8'h00, ktap(0), 1, 0};
`endif
      vecs[2] = '{0, 8'h00, ktap(4), 1, 9};
      vecs[3] = '{1, 8'h80, kfill(8'h80), 0, 147456};
      vecs[4] = '{1, 8'h7F, kfill(8'h80), 0, -146304};

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_pix_ready", pix_ready, 1);
      chk("rst_data", data, 0);
      chk("rst_weight", weight, 0);
      chk("rst_res_valid", res_valid, 0);

      // Continuous pix_valid: one accept every fourth cycle
      do_reset();
      pix_valid = 1'b1;
      acc_cnt = 0;
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge clk);
         chk("pacing_ready", pix_ready, (k % 4) == 0);
         if (pix_ready) acc_cnt++;
      end
      pix_valid = 1'b0;
      chk("pacing_count", acc_cnt, 16);

      // Full 8x8 frames through the table
      for (int v = 0; v < 5; v++) begin
         do_reset();
         feed(0, 64, vecs[v].pmode, vecs[v].pval, 1'b1, vecs[v].kern);
         repeat (12) @(negedge clk);
         chk($sformatf("v%0d_count", v), res_q.size(), 36);
         chk($sformatf("v%0d_first_rv", v), first_rv, 19);
         for (int i = 0; i < 36; i++) begin
            r0 = i / 6;
            c0 = i % 6;
            expv = vecs[v].a * (r0*8 + c0) + vecs[v].b;
            if (i < res_q.size()) chk($sformatf("v%0d_res%0d", v, i), res_q[i], expv);
         end
      end

      // Reset in phase 2 of a valid frame drops the window
      do_reset();
      feed(0, 19, 0, 8'h00, 1'b1, kfill(8'h01));
      chk("mid_data_row0", data, 24'h020100);
      chk("mid_weight_row0", weight, 24'h010101);
      @(negedge clk);
      chk("mid_data_row1", data, 24'h0A0908);
      rst = 1'b1;
      #1;
      chk("mid_rst_data", data, 0);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_ready", pix_ready, 1);
      do_reset();
      repeat (8) @(negedge clk);
      chk("mid_dropped", res_q.size(), 0);
      feed(0, 19, 0, 8'h00, 1'b1, kfill(8'h01));
      repeat (6) @(negedge clk);
      chk("restart_first_rv", first_rv, 19);
      chk("restart_count", res_q.size(), 1);
      if (res_q.size() > 0) chk("restart_res", res_q[0], 81);

      // k_load in phase 2 is ignored, in phase 0 it takes effect that frame
      do_reset();
      @(negedge clk);
      @(negedge clk);
      k_coef = kfill(8'h01);
      k_load = 1'b1;
      @(negedge clk);
      k_load = 1'b0;
      feed(0, 19, 0, 8'h00, 1'b0, '0);
      feed(19, 1, 0, 8'h00, 1'b1, kfill(8'h01));
      repeat (8) @(negedge clk);
      chk("kload_count", res_q.size(), 2);
      if (res_q.size() > 1) begin
         chk("kload_ph2_ignored", res_q[0], 0);
         chk("kload_ph0_used", res_q[1], 90);
      end

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", test_cnt, fail_cnt);
      $fatal(1);
   end

endmodule
